// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave: FSM state encoding and frame-width derivation.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WRITE     = 3'd1,
        CHK_CMD   = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } spi_state_t;

    localparam int CMD_W = 2;

    // A frame carries the two command bits followed by the payload.
    function automatic int frame_w(input int data_w);
        return data_w + CMD_W;
    endfunction

endpackage

// File: rtl/spi_tx_shifter.sv
// spi_tx_shifter: latches one read payload and serialises it onto MISO, one bit per clock.
// Latency: first MISO bit on the edge after the tx_valid/tx_ready handshake; tx_done one edge after the last bit.
// Backpressure: tx_ready low while a word is in flight; abort drops the word (tx_busy exported under SPI_SLAVE_FRAME_ERR_EN).
module spi_tx_shifter #(
    parameter int DATA_W    = 8,
    parameter int MSB_FIRST = 1,
    parameter int CNT_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              abort,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_done,
    output logic              miso
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ,
    output logic              tx_busy
`endif
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [DATA_W-1:0] word;
    logic [DATA_W-1:0] word_adv;
    logic [CNT_W-1:0]  cnt;
    logic              busy;
    logic              tx_bit;

    assign tx_ready = en && !busy;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    assign tx_busy = busy;
`endif

    always_comb begin
        if (MSB_FIRST != 0) begin
            tx_bit   = word[DATA_W-1];
            word_adv = {word[DATA_W-2:0], 1'b0};
        end else begin
            tx_bit   = word[0];
            word_adv = {1'b0, word[DATA_W-1:1]};
        end
    end

    // cnt counts bits already driven; once all DATA_W are out, the next edge closes the word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word    <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            miso    <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (abort) begin
                busy <= 1'b0;
                cnt  <= '0;
                miso <= 1'b0;
            end else if (busy) begin
                if (cnt == CNT_LAST) begin
                    busy    <= 1'b0;
                    cnt     <= '0;
                    miso    <= 1'b0;
                    tx_done <= 1'b1;
                end else begin
                    miso <= tx_bit;
                    word <= word_adv;
                    cnt  <= cnt + CNT_ONE;
                end
            end else if (tx_valid && tx_ready) begin
                word <= tx_data;
                busy <= 1'b1;
                cnt  <= '0;
            end
        end
    end

endmodule

// File: rtl/spi_slave_gen.sv
// spi_slave_gen: SPI slave decoding write / read-address / read-data frames, with MISO read-back in READ_DATA.
// Latency: rx_valid the cycle after the last frame bit; MISO starts the edge after a tx handshake.
// Backpressure: tx_ready only in READ_DATA while idle; SS_n high aborts all; SPI_SLAVE_FRAME_ERR_EN enables frame_err.
module spi_slave_gen
    import spi_pkg::*;
#(
    parameter int  DATA_W    = 8,
    parameter int  MSB_FIRST = 1,
    localparam int FRAME_W   = frame_w(DATA_W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               SS_n,
    input  logic               MOSI,
    output logic               MISO,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid,
    input  logic [DATA_W-1:0]  tx_data,
    input  logic               tx_valid,
    output logic               tx_ready,
    output logic               tx_done,
    output logic               frame_err,
    output logic [2:0]         cs_sva
);
    localparam int               CNT_W    = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    spi_state_t         cs;
    spi_state_t         ns;
    logic [CNT_W-1:0]   rx_cnt;
    logic [FRAME_W-1:0] rx_next;
    logic               add_exist;
    logic               in_frame;
    logic               abort;
    logic               shift_en;

    assign in_frame = (cs == WRITE) || (cs == READ_ADD) || (cs == READ_DATA);
    assign abort    = SS_n && (cs != IDLE);
    assign shift_en = in_frame && !SS_n && (rx_cnt < CNT_FULL);
    assign cs_sva   = cs;

    always_comb begin
        if (MSB_FIRST != 0) rx_next = {rx_data[FRAME_W-2:0], MOSI};
        else                rx_next = {MOSI, rx_data[FRAME_W-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cs <= IDLE;
        else     cs <= ns;
    end

    always_comb begin
        ns = cs;
        case (cs)
            IDLE:      if (!SS_n) ns = CHK_CMD;
            CHK_CMD: begin
                if (SS_n)           ns = IDLE;
                else if (!MOSI)     ns = WRITE;
                else if (add_exist) ns = READ_DATA;
                else                ns = READ_ADD;
            end
            WRITE, READ_ADD, READ_DATA: if (SS_n) ns = IDLE;
            default:   ns = IDLE;
        endcase
    end

    // Bits past FRAME_W are dropped; rx_data holds the frame until SS_n rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data   <= '0;
            rx_cnt    <= '0;
            rx_valid  <= 1'b0;
            add_exist <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (abort) begin
                rx_data <= '0;
                rx_cnt  <= '0;
            end else if (shift_en) begin
                rx_data <= rx_next;
                rx_cnt  <= rx_cnt + CNT_ONE;
                if (rx_cnt == CNT_LAST) begin
                    rx_valid <= 1'b1;
                    if (cs == READ_ADD)       add_exist <= 1'b1;
                    else if (cs == READ_DATA) add_exist <= 1'b0;
                end
            end
        end
    end

`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic tx_busy;
    logic err_cond;

    assign err_cond = abort && ((in_frame && (rx_cnt != '0) && (rx_cnt < CNT_FULL)) || tx_busy);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) frame_err <= 1'b0;
        else     frame_err <= err_cond;
    end
`else
    assign frame_err = 1'b0;
`endif

    spi_tx_shifter #(
        .DATA_W    (DATA_W),
        .MSB_FIRST (MSB_FIRST),
        .CNT_W     (CNT_W)
    ) u_tx (
        .clk      (clk),
        .rst      (rst),
        .en       ((cs == READ_DATA) && !SS_n),
        .abort    (abort),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_done  (tx_done),
        .miso     (MISO)
`ifdef SPI_SLAVE_FRAME_ERR_EN
        ,
        .tx_busy  (tx_busy)
`endif
    );

endmodule

// File: tb/tb_spi_slave_gen.sv
// Self-checking bench for spi_slave_gen: default 8-bit MSB-first instance plus a 12-bit LSB-first instance.
module tb_spi_slave_gen;
    localparam int DW  = 8;
    localparam int FW  = DW + 2;
    localparam int DW2 = 12;
    localparam int FW2 = DW2 + 2;

    logic          clk;
    logic          rst;
    logic          SS_n;
    logic          MOSI;
    logic          MISO;
    logic [FW-1:0] rx_data;
    logic          rx_valid;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          tx_done;
    logic          frame_err;
    logic [2:0]    cs_sva;

    logic           ss2;
    logic           mosi2;
    logic           miso2;
    logic [FW2-1:0] rx_data2;
    logic           rx_valid2;
    logic [DW2-1:0] tx_data2;
    logic           tx_valid2;
    logic           tx_ready2;
    logic           tx_done2;
    logic           frame_err2;
    logic [2:0]     cs2;

    int checks;
    int errors;
    bit add_m;

    logic           rcmd;
    bit             roff;
    int             rn;
    logic [FW-1:0]  rfrm;
    logic [DW-1:0]  rword;
    logic [FW2-1:0] frames2 [2];
    logic [FW2-1:0] sh2;

    spi_slave_gen #(.DATA_W(DW), .MSB_FIRST(1)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .SS_n      (SS_n),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_done   (tx_done),
        .frame_err (frame_err),
        .cs_sva    (cs_sva)
    );

    spi_slave_gen #(.DATA_W(DW2), .MSB_FIRST(0)) u_dut12 (
        .clk       (clk),
        .rst       (rst),
        .SS_n      (ss2),
        .MOSI      (mosi2),
        .MISO      (miso2),
        .rx_data   (rx_data2),
        .rx_valid  (rx_valid2),
        .tx_data   (tx_data2),
        .tx_valid  (tx_valid2),
        .tx_ready  (tx_ready2),
        .tx_done   (tx_done2),
        .frame_err (frame_err2),
        .cs_sva    (cs2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic ss, input logic mosi);
        SS_n = ss;
        MOSI = mosi;
        @(posedge clk);
        #1;
    endtask

    // One complete transaction: select, command bit, n_cyc data-state cycles, then deselect.
    // Expected values follow from the protocol rules: payload bit k appears on MISO after
    // the (k+1)th edge past the handshake, done one edge later; rx_valid right after bit FW.
    task automatic run_frame(input logic cmd, input logic [FW-1:0] frm, input int n_cyc,
                             input bit offer, input logic [DW-1:0] word, input int rst_at);
        int            st;
        int            bits;
        bit            eff;
        bit            busy_end;
        bit            exp_err;
        logic          exp_miso;
        logic [FW-1:0] fsh;
        logic [DW-1:0] wsh;

        fsh = frm;
        wsh = word;
        step(1'b0, 1'($urandom));
        chk("cs_chk_cmd", 32'(cs_sva), 2);
        st = cmd ? (add_m ? 4 : 3) : 1;
        step(1'b0, cmd);
        chk("cs_data_state", 32'(cs_sva), 32'(st));
        chk("tx_ready_entry", 32'(tx_ready), 32'(st == 4));
        eff = offer && (st == 4);

        for (int c = 0; c < n_cyc; c++) begin
            tx_valid = offer && (c == 0);
            tx_data  = word;
            if (c < FW) begin
                step(1'b0, fsh[FW-1]);
                fsh = fsh << 1;
            end else begin
                step(1'b0, 1'($urandom));
            end
            tx_valid = 1'b0;
            if (eff && c >= 1 && c <= DW) begin
                exp_miso = wsh[DW-1];
                wsh      = wsh << 1;
            end else begin
                exp_miso = 1'b0;
            end
            chk("miso_bit", 32'(MISO), 32'(exp_miso));
            chk("tx_done", 32'(tx_done), 32'(eff && (c == DW + 1)));
            chk("tx_ready", 32'(tx_ready), 32'((st == 4) && !(eff && c <= DW)));
            chk("rx_valid", 32'(rx_valid), 32'(c == FW - 1));
            chk("cs_hold", 32'(cs_sva), 32'(st));
            if (c >= FW - 1) chk("rx_data", 32'(rx_data), 32'(frm));

            if (c == rst_at) begin
                SS_n = 1'b1;
                rst  = 1'b1;
                #1;
                chk("rst_miso", 32'(MISO), 0);
                chk("rst_cs", 32'(cs_sva), 0);
                chk("rst_tx_ready", 32'(tx_ready), 0);
                chk("rst_rx_data", 32'(rx_data), 0);
                add_m = 1'b0;
                @(posedge clk);
                @(posedge clk);
                #1;
                rst = 1'b0;
                for (int k = 0; k < DW + 4; k++) begin
                    step(1'b1, 1'b0);
                    chk("no_done_after_rst", 32'(tx_done), 0);
                    chk("miso_after_rst", 32'(MISO), 0);
                end
                return;
            end
        end

        bits     = (n_cyc < FW) ? n_cyc : FW;
        busy_end = eff && (n_cyc <= DW + 1);
`ifdef SPI_SLAVE_FRAME_ERR_EN
        exp_err = (bits > 0 && bits < FW) || busy_end;
`else
        exp_err = 1'b0;
`endif
        step(1'b1, 1'b0);
        chk("abort_cs", 32'(cs_sva), 0);
        chk("abort_rx_data", 32'(rx_data), 0);
        chk("abort_miso", 32'(MISO), 0);
        chk("abort_tx_done", 32'(tx_done), 0);
        chk("abort_rx_valid", 32'(rx_valid), 0);
        chk("abort_tx_ready", 32'(tx_ready), 0);
        chk("frame_err", 32'(frame_err), 32'(exp_err));
        if (bits == FW) begin
            if (st == 3)      add_m = 1'b1;
            else if (st == 4) add_m = 1'b0;
        end
        step(1'b1, 1'b0);
        chk("frame_err_pulse", 32'(frame_err), 0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        add_m     = 1'b0;
        rst       = 1'b1;
        SS_n      = 1'b1;
        MOSI      = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = '0;
        ss2       = 1'b1;
        mosi2     = 1'b0;
        tx_valid2 = 1'b0;
        tx_data2  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_cs", 32'(cs_sva), 0);
        chk("reset_rx_data", 32'(rx_data), 0);
        chk("reset_rx_valid", 32'(rx_valid), 0);
        chk("reset_miso", 32'(MISO), 0);
        chk("reset_tx_ready", 32'(tx_ready), 0);
        chk("reset_tx_done", 32'(tx_done), 0);
        chk("reset_frame_err", 32'(frame_err), 0);
        rst = 1'b0;
        step(1'b1, 1'b0);
        chk("idle_hold", 32'(cs_sva), 0);

        run_frame(1'b0, 10'h0AA, FW + 2, 1'b0, 8'h00, -1);
        run_frame(1'b0, FW'($urandom), FW, 1'b1, DW'($urandom), -1);
        run_frame(1'b1, 10'h205, FW + 1, 1'b0, 8'h00, -1);
        run_frame(1'b1, FW'($urandom), FW + 2, 1'b1, 8'hC3, -1);
        run_frame(1'b1, FW'($urandom), FW, 1'b0, 8'h00, -1);
        run_frame(1'b0, FW'($urandom), 5, 1'b0, 8'h00, -1);
        run_frame(1'b1, FW'($urandom), 4, 1'b0, 8'h00, -1);
        run_frame(1'b1, FW'($urandom), FW, 1'b0, 8'h00, -1);
        run_frame(1'b1, FW'($urandom), 4, 1'b1, DW'($urandom), -1);
        run_frame(1'b1, FW'($urandom), FW + 3, 1'b1, 8'hA5, 4);
        run_frame(1'b1, FW'($urandom), FW, 1'b0, 8'h00, -1);

        for (int i = 0; i < 24; i++) begin
            rcmd  = 1'($urandom);
            roff  = 1'($urandom);
            rn    = $urandom_range(1, FW + 3);
            rfrm  = FW'($urandom);
            rword = DW'($urandom);
            run_frame(rcmd, rfrm, rn, roff, rword, -1);
        end

        frames2[0] = 14'h2ABC;
        frames2[1] = FW2'($urandom);
        for (int f = 0; f < 2; f++) begin
            ss2 = 1'b0;
            @(posedge clk);
            #1;
            chk("dut12_cs_chk_cmd", 32'(cs2), 2);
            mosi2 = 1'b0;
            @(posedge clk);
            #1;
            chk("dut12_cs_write", 32'(cs2), 1);
            sh2 = frames2[f];
            for (int c = 0; c < FW2; c++) begin
                mosi2 = sh2[0];
                sh2   = sh2 >> 1;
                @(posedge clk);
                #1;
                chk("dut12_rx_valid", 32'(rx_valid2), 32'(c == FW2 - 1));
            end
            chk("dut12_rx_data", 32'(rx_data2), 32'(frames2[f]));
            ss2 = 1'b1;
            @(posedge clk);
            #1;
            chk("dut12_abort_cs", 32'(cs2), 0);
            chk("dut12_abort_rx_data", 32'(rx_data2), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
